tcdm_bank_resp: RTL

Single-port TCDM bank responder. It sits on one slave port of the banked interconnect and serves the request/grant protocol that the network drives: grants requests, performs byte-enabled reads and writes on an internal flop-array memory, and returns read data exactly one cycle after the grant. A built-in grant throttler produces deterministic back-pressure patterns so interconnect arbitration can be stressed in simulation and in FPGA bring-up.

---
 rtl/tcdm_bank_resp.sv | 111 +++++++++++
 1 files changed

// File: rtl/tcdm_bank_resp.sv
// Single-port TCDM bank responder: request/grant slave with byte-enabled flop memory,
// 1-cycle read latency, and a deterministic grant throttler for back-pressure testing.
module tcdm_bank_resp #(
    parameter int unsigned  NumWords     = 256,
    parameter int unsigned  DataWidth    = 32,
    localparam int unsigned AddWidth     = $clog2(NumWords),
    localparam int unsigned BeWidth      = DataWidth / 8,
    localparam int unsigned ReqDataWidth = DataWidth + BeWidth + 1,
    parameter logic [15:0]  LfsrSeed     = 16'hACE1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [AddWidth-1:0]     add_i,
    input  logic [ReqDataWidth-1:0] data_i,
    output logic [DataWidth-1:0]    rdata_o,
    input  logic [1:0]              stall_mode_i,
    output logic [31:0]             rd_cnt_o,
    output logic [31:0]             wr_cnt_o
);

    typedef enum logic [1:0] {
        ModeAlways = 2'd0,
        ModeAlt    = 2'd1,
        ModeLfsr   = 2'd2,
        ModeNever  = 2'd3
    } stall_mode_e;

    logic [DataWidth-1:0] mem_q [NumWords];

    logic                 phase_q, phase_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic [31:0]          rd_cnt_q, rd_cnt_d;
    logic [31:0]          wr_cnt_q, wr_cnt_d;

    logic                 allow;
    logic                 hs;
    logic                 wen;
    logic [BeWidth-1:0]   be;
    logic [DataWidth-1:0] wdata;
    logic                 mem_we;
    logic [DataWidth-1:0] wr_word;

    assign wen   = data_i[ReqDataWidth-1];
    assign be    = data_i[DataWidth +: BeWidth];
    assign wdata = data_i[DataWidth-1:0];

    always_comb begin
        allow = 1'b0;
        case (stall_mode_e'(stall_mode_i))
            ModeAlways: allow = 1'b1;
            ModeAlt:    allow = ~phase_q;
            ModeLfsr:   allow = lfsr_q[0];
            ModeNever:  allow = 1'b0;
            default:    allow = 1'b0;
        endcase
    end

    assign gnt_o = req_i & allow & ~rst_i;
    assign hs    = req_i & gnt_o;

    always_comb begin
        phase_d  = ~phase_q;
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        rdata_d  = rdata_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        mem_we   = 1'b0;
        wr_word  = mem_q[add_i];
        if (hs) begin
            if (wen) begin
                rdata_d  = mem_q[add_i];
                rd_cnt_d = rd_cnt_q + 32'd1;
            end else begin
                mem_we   = 1'b1;
                wr_cnt_d = wr_cnt_q + 32'd1;
                for (int unsigned i = 0; i < BeWidth; i++) begin
                    if (be[i]) wr_word[8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q  <= 1'b0;
            lfsr_q   <= LfsrSeed;
            rdata_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            phase_q  <= phase_d;
            lfsr_q   <= lfsr_d;
            rdata_q  <= rdata_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Contents survive reset; no write can occur during reset since gnt_o is masked.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[add_i] <= wr_word;
    end

    assign rdata_o  = rdata_q;
    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;

endmodule
